// File: rtl/alu_flags_stage_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_flags_stage_if
//  Brief    : Upstream/downstream handshake bundle for the ALU flags stage.
//             The master side produces results and consumes outputs; the
//             slave side is the registered flags stage itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_flags_stage_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  // Upstream (mux side) handshake and payload
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_result;
  logic [3:0]       in_op;
  logic             in_carry;
  logic             in_overflow;

  // Downstream (consumer side) handshake and payload
  logic             out_valid;
  logic             out_ready;
  logic [N:0]       out_result;
  logic [3:0]       out_op;
  logic [3:0]       out_flags;

  // Status
  logic [CNT_W-1:0] illegal_cnt;

  // Producer of results and consumer of the stage outputs
  modport master (
    output in_valid, in_result, in_op, in_carry, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_flags, illegal_cnt
  );

  // The flags stage
  modport slave (
    input  in_valid, in_result, in_op, in_carry, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_op, out_flags, illegal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/alu_flags_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_flags_stage
//  Brief    : Registered output stage behind the ALU result mux. Captures the
//             result and op code, derives the N/Z/C/V flags, and presents
//             them over valid/ready through a two-entry skid buffer so that
//             in_ready is driven straight from a flop. Counts accepted
//             illegal op codes (1010..1111) in a saturating counter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flags_stage #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  alu_flags_stage_if.slave    bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // First op code the mux treats as undefined; everything at or above it is
  // transferred unchanged but counted.
  localparam logic [3:0]       c_ILLEGAL_OP_MIN = 4'b1010;
  // Op codes whose result comes from the adder and therefore carry C/V.
  localparam logic [3:0]       c_OP_ADD         = 4'b0000;
  localparam logic [3:0]       c_OP_SUB         = 4'b0001;
  localparam logic [CNT_W-1:0] c_CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Occupancy state. The encoding is literally {skid_valid, main_valid}, so
  // the valid bits of both entries fall straight out of the state register.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;

  // Main entry: drives the out_* fields directly
  logic [N:0]       main_result_q;
  logic [3:0]       main_op_q;
  logic [3:0]       main_flags_q;

  // Skid entry: absorbs the one beat that arrives while the consumer stalls
  logic [N:0]       skid_result_q;
  logic [3:0]       skid_op_q;
  logic [3:0]       skid_flags_q;

  logic [CNT_W-1:0] illegal_cnt_q;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic             main_valid;
  logic             accept;
  logic             pop;

  assign main_valid = state_q[0];
  assign accept     = bus.in_valid & in_ready_q;
  assign pop        = main_valid & bus.out_ready;

  // --------------------------------------------------------------------------
  // Flag derivation on the incoming beat
  // --------------------------------------------------------------------------
  logic             is_arith;
  logic             is_illegal;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic [3:0]       new_flags;

  // Only add/subtract results have a meaningful carry and overflow; for all
  // other ops the adder outputs are stale and must be masked.
  assign is_arith   = (bus.in_op == c_OP_ADD) || (bus.in_op == c_OP_SUB);
  assign is_illegal = (bus.in_op >= c_ILLEGAL_OP_MIN);
  assign flag_n     = bus.in_result[N];
  assign flag_z     = (bus.in_result == '0);
  assign flag_c     = is_arith & bus.in_carry;
  assign flag_v     = is_arith & bus.in_overflow;
  assign new_flags  = {flag_n, flag_z, flag_c, flag_v};

  // --------------------------------------------------------------------------
  // Next occupancy state from accept/pop
  // --------------------------------------------------------------------------
  // Next-state decode: FULL can only pop because in_ready is low there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_ONE;
      end
      ST_ONE: begin
        if (accept && !pop)      state_d = ST_FULL;
        else if (!accept && pop) state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop) state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, storage, ready and counter registers
  // --------------------------------------------------------------------------
  // All registered state; in_ready is looked ahead from state_d so that it is
  // a plain flop output and still drops the cycle after the skid fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b0;
      main_result_q <= '0;
      main_op_q     <= '0;
      main_flags_q  <= '0;
      skid_result_q <= '0;
      skid_op_q     <= '0;
      skid_flags_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);

      unique case (state_q)
        // Nothing held: a new beat goes straight to the output entry.
        ST_EMPTY: begin
          if (accept) begin
            main_result_q <= bus.in_result;
            main_op_q     <= bus.in_op;
            main_flags_q  <= new_flags;
          end
        end
        // One held: replace it if it leaves this cycle, else park in skid.
        ST_ONE: begin
          if (accept && pop) begin
            main_result_q <= bus.in_result;
            main_op_q     <= bus.in_op;
            main_flags_q  <= new_flags;
          end else if (accept) begin
            skid_result_q <= bus.in_result;
            skid_op_q     <= bus.in_op;
            skid_flags_q  <= new_flags;
          end
        end
        // Both held: the older skid beat advances once main is consumed.
        ST_FULL: begin
          if (pop) begin
            main_result_q <= skid_result_q;
            main_op_q     <= skid_op_q;
            main_flags_q  <= skid_flags_q;
          end
        end
        default: ;
      endcase

      // Illegal ops are counted when they enter the stage, not when they leave.
      if (accept && is_illegal && (illegal_cnt_q != '1)) begin
        illegal_cnt_q <= illegal_cnt_q + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid;
  assign bus.out_result  = main_result_q;
  assign bus.out_op      = main_op_q;
  assign bus.out_flags   = main_flags_q;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_flags_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_flags_stage
//  Brief    : Scoreboard bench for alu_flags_stage. Accepted beats push their
//             expected output into a queue; an independent monitor pops and
//             compares whenever the stage hands a beat to the consumer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flags_stage;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;

  alu_flags_stage_if #(.N(N), .CNT_W(CNT_W)) bus ();

  alu_flags_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N:0] result;
    logic [3:0] op;
    logic [3:0] flags;
    int         acc_edge;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cnt_m  = 0;
  int   cyc    = 0;
  bit   stream_mode = 0;
  bit   bp_en = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference flags, straight from the arithmetic meaning of each flag
  function automatic logic [3:0] model_flags(input logic [N:0] r, input logic [3:0] op,
                                             input logic c, input logic v);
    int  val;
    bit  from_adder;
    logic [3:0] f;
    val        = int'(r);
    from_adder = (op == 4'd0) || (op == 4'd1);
    f[3] = (val >= (1 << N));
    f[2] = (val == 0);
    f[1] = from_adder && c;
    f[0] = from_adder && v;
    return f;
  endfunction

  // Acceptance side: check counter, then record any beat accepted at the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      check("illegal_cnt", 32'(bus.illegal_cnt), 32'(cnt_m));
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.result   = bus.in_result;
        e.op       = bus.in_op;
        e.flags    = model_flags(bus.in_result, bus.in_op, bus.in_carry, bus.in_overflow);
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        if (int'(bus.in_op) >= 10 && cnt_m < 255) cnt_m++;
      end
    end
  end

  // Output side monitor: hold stability and in-order delivery
  bit         hold_chk = 0;
  logic [N:0] h_result;
  logic [3:0] h_op, h_flags;
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_result", 32'(bus.out_result), 32'(h_result));
        check("hold_op", 32'(bus.out_op), 32'(h_op));
        check("hold_flags", 32'(bus.out_flags), 32'(h_flags));
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else if (bus.out_ready) begin
          exp_t e;
          e = sb.pop_front();
          check("out_result", 32'(bus.out_result), 32'(e.result));
          check("out_op", 32'(bus.out_op), 32'(e.op));
          check("out_flags", 32'(bus.out_flags), 32'(e.flags));
          if (stream_mode) check("latency", 32'(cyc + 1), 32'(e.acc_edge + 1));
        end
      end
      hold_chk = bus.out_valid && !bus.out_ready;
      h_result = bus.out_result;
      h_op     = bus.out_op;
      h_flags  = bus.out_flags;
    end
  end

  // Present one beat and wait (bounded) until it is accepted; returns at posedge+1
  task automatic send(input logic [N:0] r, input logic [3:0] op, input logic c,
                      input logic v, input bit chk_stream);
    bit ok;
    bus.in_valid    = 1'b1;
    bus.in_result   = r;
    bus.in_op       = op;
    bus.in_carry    = c;
    bus.in_overflow = v;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (chk_stream && i == 0) check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (bus.in_ready && !rst) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; returns at posedge+1 after release
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle();
    sb.delete();
    cnt_m = 0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    check("rst_out_op", 32'(bus.out_op), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("rel_in_ready_pre", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_post", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_op       = '0;
    bus.in_carry    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    do_reset();

    // Directed flag patterns
    send(5'b00000, 4'b0000, 1'b1, 1'b1, 0);
    idle();
    @(negedge clk);
    check("flags_add_zero", 32'(bus.out_flags), 32'h7);
    @(posedge clk); #1;
    send(5'b10000, 4'b0010, 1'b1, 1'b0, 0);
    idle();
    @(negedge clk);
    check("flags_neg_logic", 32'(bus.out_flags), 32'h8);
    @(posedge clk); #1;
    drain();

    // Streaming: 20 back-to-back beats, one-cycle latency, in_ready always high
    stream_mode = 1;
    for (int i = 0; i < 20; i++)
      send(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    idle();
    drain();
    stream_mode = 0;

    // Backpressure: two beats stored, third held upstream, then released in order
    bus.out_ready = 1'b0;
    send(5'd1, 4'b0010, 1'b0, 1'b0, 0);
    send(5'd2, 4'b0010, 1'b0, 1'b0, 0);
    bus.in_valid  = 1'b1;
    bus.in_result = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp_head_result", 32'(bus.out_result), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(5'd3, 4'b0010, 1'b0, 1'b0, 0);
    idle();
    drain();

    // Randomized traffic with random consumer stalls and idle gaps
    bp_en = 1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
          send(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        idle();
        bp_en = 0;
      end
      begin
        while (bp_en) begin
          @(posedge clk); #1;
          if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Illegal ops: counter saturates, C/V masked, result untouched
    for (int i = 0; i < 300; i++)
      send(5'($urandom_range(0, 31)), 4'b1011, 1'b1, 1'b1, 0);
    idle();
    drain();
    check("illegal_saturated", 32'(bus.illegal_cnt), 32'd255);

    // Reset while FULL: nothing stale may come out afterwards
    bus.out_ready = 1'b0;
    send(5'd9, 4'b0000, 1'b1, 1'b0, 0);
    send(5'd10, 4'b0000, 1'b0, 1'b1, 0);
    bus.in_valid  = 1'b1;
    bus.in_result = 5'd11;
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      send(5'(20 + i), 4'b0011, 1'b0, 1'b0, 0);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_flags_stage.md
# alu_flags_stage

Registered output stage placed directly downstream of the ALU result multiplexer (`muxN`). It captures the selected result together with the operation code, derives the condition flags N, Z, C and V, and hands them to the consumer over a valid/ready handshake. A two-entry skid buffer lets the upstream side see a fully registered `in_ready` without losing throughput. A saturating counter records accepted illegal operation codes.

## Interface
- N, default 4: MSB index of the data path; result width is N+1 bits, matching the mux output.
- CNT_W, default 8: width of the illegal-op counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream holds a valid result.
- in_ready  out  1  stage can accept; registered.
- in_result  in  N+1  mux output Q.
- in_op  in  4  ALUControl value that selected in_result.
- in_carry  in  1  adder carry-out / borrow.
- in_overflow  in  1  adder signed overflow.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  consumer accepts.
- out_result  out  N+1  registered result.
- out_op  out  4  registered op code.
- out_flags  out  4  {N, Z, C, V}.
- illegal_cnt  out  CNT_W  saturating count of accepted ops 1010..1111.

## Operation
- Flag rules, computed on in_* at acceptance:
  - N = in_result[N].
  - Z = (in_result == 0).
  - C = in_carry when in_op is 0000 or 0001, else 0.
  - V = in_overflow when in_op is 0000 or 0001, else 0.
- Op codes 1010..1111 are legal to transfer: result passes unchanged (the mux has already defaulted it to I0), flags follow the rules above (C = V = 0), and illegal_cnt increments by 1, saturating at all-ones.
- Storage has two entries, main (drives out_*) and skid. Each entry holds {result, op, flags, valid}.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- State, encoded by {skid_valid, main_valid}:
  - EMPTY (00), Accept → ONE.
  - ONE (01):
    - Accept & Pop → ONE, with main replaced.
    - Accept & !Pop → FULL, with the new beat in skid.
    - Pop & !Accept → EMPTY.
  - FULL (11):
    - Pop → ONE, with skid moved to main. No accept is possible because in_ready = 0.
- in_ready = !skid_valid, registered from the next state.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- out_* fields hold stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out_valid = 0, in_ready = 0.
  - out_result = 0, out_op = 0, out_flags = 0.
  - illegal_cnt = 0, skid cleared.
  - In the first clk edge after rst deasserts, in_ready rises to 1 with state EMPTY.
- Latency: a beat accepted at edge k appears on out_* with out_valid = 1 after edge k; it is poppable at edge k+1.
- Throughput is 1 beat/cycle when out_ready is held high.
- in_ready drops 1 cycle after the stall in which the skid fills, and rises the cycle after a pop from FULL.
- illegal_cnt updates at the acceptance edge, not at pop.
- If rst asserts mid-transfer, all in-flight beats are discarded. illegal_cnt is not retained.

## Test plan
- Reset: assert rst asynchronously between edges → out_valid, in_ready, out_flags and illegal_cnt read 0 before the next edge. After release, in_ready = 1 after one edge.
- Flags (N=4):
  - op 0000, result 5'b00000, carry 1, overflow 1 → flags 4'b0111.
  - op 0010, result 5'b10000, carry 1 → flags 4'b1000.
- Streaming: 20 back-to-back beats with out_ready = 1 → 20 outputs in order, each 1 cycle later, in_ready constantly 1.
- Backpressure: out_ready = 0 with 3 offered beats → beats 1 and 2 are stored, in_ready = 0 from the third cycle, and beat 3 is held by upstream. Releasing out_ready → order 1, 2, 3 and no loss.
- Illegal ops: 300 accepted beats with op 1011 and CNT_W = 8 → illegal_cnt saturates at 255. Each of these beats outputs C = V = 0 and the unchanged result.
- Reset while in FULL → both entries discarded, out_valid = 0, no stale beat appears after release.
